// File: rtl/regfile_param.sv
// XLEN x NREG register file: two registered read ports, one write port, and a hardware clear sweep after reset.
// Optional macro REGFILE_BYPASS_EN forwards write data to a colliding read port (write-first forwarding).
module regfile_param #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic            re,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            we,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rvalid,
  output logic            busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] x [NREG];

  logic            wr_ok;
  logic            col1;
  logic            col2;
  logic [XLEN-1:0] rdat1;
  logic [XLEN-1:0] rdat2;

  // A write to entry 0 is dropped, so it can never collide with a read of 0.
  assign wr_ok = we && (wa1 != '0);
  assign col1  = re && wr_ok && (wa1 == ra1);
  assign col2  = re && wr_ok && (wa1 == ra2);
  assign rdat1 = (ra1 == '0) ? '0 : x[ra1];
  assign rdat2 = (ra2 == '0) ? '0 : x[ra2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        x[clr_cnt] <= '0;
      else if (wr_ok)
        x[wa1] <= wd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      rd1     <= '0;
      rd2     <= '0;
      rvalid  <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          rvalid  <= 1'b0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          rvalid <= 1'b0;
          if (re) begin
`ifdef REGFILE_BYPASS_EN
            rd1    <= col1 ? wd1 : rdat1;
            rd2    <= col2 ? wd1 : rdat2;
            rvalid <= 1'b1;
`else
            // Colliding port keeps its old value and the missing rvalid asks for a re-read.
            if (!col1) rd1 <= rdat1;
            if (!col2) rd2 <= rdat2;
            rvalid <= !(col1 || col2);
`endif
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: reference model in plain arrays, monitor pops expected reads on rvalid.
module tb_regfile_param;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   ra1 = '0;
  logic [AW-1:0]   ra2 = '0;
  logic            re  = 1'b0;
  logic [AW-1:0]   wa1 = '0;
  logic [XLEN-1:0] wd1 = '0;
  logic            we  = 1'b0;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            rvalid;
  logic            busy;

  regfile_param #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .re(re),
    .wa1(wa1), .wd1(wd1), .we(we),
    .rd1(rd1), .rd2(rd2), .rvalid(rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]   mem [NREG];
  int                sweep_left = NREG;
  logic [XLEN-1:0]   last_rd1 = '0;
  logic [XLEN-1:0]   last_rd2 = '0;
  logic [2*XLEN-1:0] expq [$];

  function automatic void chk(string name, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Monitor: every presented read result is matched against the oldest expectation.
  initial begin
    logic [2*XLEN-1:0] e;
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        if (expq.size() == 0) begin
          chk("spurious_rvalid", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("rd1", rd1, e[2*XLEN-1:XLEN]);
          chk("rd2", rd2, e[XLEN-1:0]);
        end
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic rr, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic            c1, c2, hold_chk;
    logic [XLEN-1:0] e1, e2;
    rst = r; we = w; wa1 = wa; wd1 = wd; re = rr; ra1 = a1; ra2 = a2;
    hold_chk = 1'b0;
    if (!r && sweep_left == 0 && rr) begin
      c1 = w && (wa != 0) && (wa == a1);
      c2 = w && (wa != 0) && (wa == a2);
      e1 = (a1 == 0) ? '0 : mem[a1];
      e2 = (a2 == 0) ? '0 : mem[a2];
`ifdef REGFILE_BYPASS_EN
      if (c1) e1 = wd;
      if (c2) e2 = wd;
      expq.push_back({e1, e2});
      last_rd1 = e1;
      last_rd2 = e2;
`else
      if (c1 || c2) begin
        hold_chk = 1'b1;
        if (!c1) last_rd1 = e1;
        if (!c2) last_rd2 = e2;
      end else begin
        expq.push_back({e1, e2});
        last_rd1 = e1;
        last_rd2 = e2;
      end
`endif
    end
    @(posedge clk);
    if (r) begin
      sweep_left = NREG;
      last_rd1 = '0;
      last_rd2 = '0;
      for (int i = 0; i < NREG; i++) mem[i] = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else if (w && wa != 0) begin
      mem[wa] = wd;
    end
    #1;
    chk("busy", {31'd0, busy}, {31'd0, (sweep_left != 0)});
    if (sweep_left != 0) begin
      chk("rd1_clear", rd1, '0);
      chk("rvalid_clear", {31'd0, rvalid}, 32'd0);
    end
    if (hold_chk) begin
      chk("rvalid_collide", {31'd0, rvalid}, 32'd0);
      chk("rd1_hold", rd1, last_rd1);
      chk("rd2_hold", rd2, last_rd2);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    @(negedge clk);
    // Reset held two cycles, then the full sweep.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < NREG; i++) idle();
    for (int i = 1; i < NREG; i += 2)
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), AW'((i + 1) % NREG));

    // Write then read.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd0);

    // Entry 0 stays zero.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 5'd5);

    // Collision on port 1, then re-read.
    step(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd3);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd3);
    step(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd9);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9);

    // Reset restarted at sweep cycle 10; accesses during busy are masked.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < NREG; i++) step(1'b0, 1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd7);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd7);

    // Random traffic over a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      step(r, 1'($urandom), AW'($urandom_range(0, 7)), $urandom, 1'($urandom),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle();
    idle();
    chk("drain", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
